// File: rtl/adder_bist_pkg.sv
// Shared types and sizing helpers for the adder BIST checker.
// ADDER_BIST_CIN_SWEEP_EN widens the vector index so Cin is swept as its MSB.
package adder_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  localparam int DEF_WIDTH = 4;

`ifdef ADDER_BIST_CIN_SWEEP_EN
  localparam bit CIN_SWEEP = 1'b1;
`else
  localparam bit CIN_SWEEP = 1'b0;
`endif

  function automatic int idx_width(input int width);
    return CIN_SWEEP ? 2 * width + 1 : 2 * width;
  endfunction

  function automatic int vec_count(input int width);
    return 1 << idx_width(width);
  endfunction

  function automatic int err_width(input int width);
    return 2 * width + 2;
  endfunction

  // The settle counter only ever holds SETTLE-1.
  function automatic int settle_width(input int settle);
    return (settle > 1) ? $clog2(settle) : 1;
  endfunction

  function automatic longint err_sat(input int width);
    return (longint'(1) << err_width(width)) - 1;
  endfunction

  localparam int DEF_IDX_W   = idx_width(DEF_WIDTH);
  localparam int DEF_NUM_VEC = vec_count(DEF_WIDTH);
  localparam int DEF_ERR_W   = err_width(DEF_WIDTH);

endpackage

// File: rtl/adder_bist_checker_vec_gen.sv
// Vector index counter for the adder BIST sweep; last flags the final vector.
// Index width already accounts for ADDER_BIST_CIN_SWEEP_EN via the caller.
module bist_vec_gen #(
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             adv,
  output logic [IDX_W-1:0] idx,
  output logic             last
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      idx <= '0;
    else if (clr)
      idx <= '0;
    else if (adv)
      idx <= idx + 1'b1;
  end

  assign last = &idx;

endmodule

// File: rtl/adder_bist_checker.sv
// On-chip sweep checker for a ripple adder: drives vectors, compares against a golden sum.
// ADDER_BIST_CIN_SWEEP_EN: sweep Cin as index MSB; otherwise Cin is held at 1.
//
// state     | meaning
// IDLE      | waiting for start after reset
// HOLD      | vector driven, letting the adder settle
// SAMPLE    | compare adder outputs, record errors, advance
// DONE      | results valid, waiting for a restart
module adder_bist_checker
  import adder_bist_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [WIDTH-1:0]     FA,
  output logic [WIDTH-1:0]     FB,
  output logic                 Cin,
  input  logic [WIDTH-1:0]     Sum,
  input  logic                 Cout,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH+1:0]   err_cnt,
  output logic                 fail_valid,
  output logic [2*WIDTH:0]     fail_vec
);

  localparam int IDX_W = idx_width(WIDTH);
  localparam int ERR_W = err_width(WIDTH);
  localparam int SET_W = settle_width(SETTLE);
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE - 1);
  localparam logic [ERR_W-1:0] ERR_SAT     = ERR_W'(err_sat(WIDTH));

  state_t           state;
  logic [SET_W-1:0] settle_cnt;
  logic [IDX_W-1:0] idx;
  logic             last;
  logic             launch;
  logic             adv;
  logic [WIDTH:0]   golden;
  logic             mismatch;
  logic [ERR_W-1:0] err_nxt;
  logic [2*WIDTH:0] cur_vec;

  assign launch = start && (state == ST_IDLE || state == ST_DONE);
  assign adv    = (state == ST_SAMPLE) && !last;

  bist_vec_gen #(
    .IDX_W (IDX_W)
  ) u_vec_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (launch),
    .adv  (adv),
    .idx  (idx),
    .last (last)
  );

  // Operands come straight from the index register, so they only move on HOLD entry.
  assign FB = idx[WIDTH-1:0];
  assign FA = idx[2*WIDTH-1:WIDTH];
`ifdef ADDER_BIST_CIN_SWEEP_EN
  assign Cin = idx[IDX_W-1];
`else
  assign Cin = 1'b1;
`endif

  assign cur_vec  = {Cin, FA, FB};
  assign golden   = {1'b0, FA} + {1'b0, FB} + {{WIDTH{1'b0}}, Cin};
  assign mismatch = ({Cout, Sum} != golden);
  assign err_nxt  = (mismatch && err_cnt != ERR_SAT) ? err_cnt + 1'b1 : err_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state      <= ST_HOLD;
            settle_cnt <= SETTLE_LOAD;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
          end
        end
        ST_HOLD: begin
          if (settle_cnt == '0)
            state <= ST_SAMPLE;
          else
            settle_cnt <= settle_cnt - 1'b1;
        end
        ST_SAMPLE: begin
          err_cnt <= err_nxt;
          if (mismatch && !fail_valid) begin
            fail_vec   <= cur_vec;
            fail_valid <= 1'b1;
          end
          if (last) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_nxt == '0);
          end else begin
            state      <= ST_HOLD;
            settle_cnt <= SETTLE_LOAD;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_bist_checker.sv
// Self-checking bench for adder_bist_checker with a fault-injectable adder model.
module tb_adder_bist_checker;

  localparam int W = 4;
  localparam int S = 2;
`ifdef ADDER_BIST_CIN_SWEEP_EN
  localparam bit SWEEP = 1'b1;
`else
  localparam bit SWEEP = 1'b0;
`endif
  localparam int N         = SWEEP ? 512 : 256;
  localparam int SWEEP_CYC = N * (S + 1) + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] FA, FB, Sum;
  logic         Cin, Cout;
  logic         busy, done, pass, fail_valid;
  logic [2*W+1:0] err_cnt;
  logic [2*W:0]   fail_vec;

  int mode;
  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         cycles;
    int         errs;
    bit         fvalid;
    logic [8:0] fvec;
    bit         pass;
  } exp_t;

  exp_t exp_q[$];

  adder_bist_checker #(.WIDTH(W), .SETTLE(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .FA         (FA),
    .FB         (FB),
    .Cin        (Cin),
    .Sum        (Sum),
    .Cout       (Cout),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_cnt    (err_cnt),
    .fail_valid (fail_valid),
    .fail_vec   (fail_vec)
  );

  always #5 clk = ~clk;

  // Adder under test: mode 0 ideal, 1 Cout stuck at 0, 2 Sum[0] stuck at 0.
  logic [W:0] raw;
  always_comb begin
    raw  = {1'b0, FA} + {1'b0, FB} + {{W{1'b0}}, Cin};
    Sum  = raw[W-1:0];
    Cout = raw[W];
    if (mode == 1) Cout = 1'b0;
    if (mode == 2) Sum[0] = 1'b0;
  end

  // Expected results over the first 'limit' vectors of the sweep order.
  function automatic exp_t model(input int m, input int limit);
    exp_t       e;
    int         k;
    logic [4:0] g, o;
    e.cycles = SWEEP_CYC;
    e.errs   = 0;
    e.fvalid = 1'b0;
    e.fvec   = '0;
    k        = 0;
    for (int c = (SWEEP ? 0 : 1); c <= 1; c++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++) begin
          if (k < limit) begin
            g = 5'(a + b + c);
            o = g;
            if (m == 1) o[4] = 1'b0;
            if (m == 2) o[0] = 1'b0;
            if (o != g) begin
              if (e.errs < 1023) e.errs++;
              if (!e.fvalid) begin
                e.fvalid = 1'b1;
                e.fvec   = 9'(c * 256 + a * 16 + b);
              end
            end
          end
          k++;
        end
    e.pass = (e.errs == 0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_fa"}, 32'(FA), 0);
    chk({tag, "_fb"}, 32'(FB), 0);
    chk({tag, "_cin"}, 32'(Cin), SWEEP ? 0 : 1);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_pass"}, 32'(pass), 0);
    chk({tag, "_err"}, 32'(err_cnt), 0);
    chk({tag, "_fvalid"}, 32'(fail_valid), 0);
    chk({tag, "_fvec"}, 32'(fail_vec), 0);
  endtask

  task automatic start_sweep(input int m);
    @(negedge clk);
    mode = m;
    exp_q.push_back(model(m, N));
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("first_busy", 32'(busy), 1);
    chk("first_vec", 32'({FA, FB}), 0);
    chk("first_done_clr", 32'(done), 0);
    chk("first_err_clr", 32'(err_cnt), 0);
    chk("first_fvalid_clr", 32'(fail_valid), 0);
  endtask

  task automatic wait_done(input int repulse, output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < 6000) begin
      start = (cyc == repulse);
      if (cyc == repulse) chk("repulse_vec", 32'({FA, FB}), 10);
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    chk("done_seen", 32'(done), 1);
  endtask

  task automatic finish_sweep(input string tag, input int cyc);
    exp_t e;
    e = exp_q.pop_front();
    chk({tag, "_cycles"}, 32'(cyc), 32'(e.cycles));
    chk({tag, "_err"}, 32'(err_cnt), 32'(e.errs));
    chk({tag, "_fvalid"}, 32'(fail_valid), 32'(e.fvalid));
    chk({tag, "_fvec"}, 32'(fail_vec), 32'(e.fvec));
    chk({tag, "_pass"}, 32'(pass), 32'(e.pass));
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    int   cyc;
    exp_t part;
    rst   = 1'b1;
    start = 1'b0;
    mode  = 0;
    #12;
    chk_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;

    start_sweep(0);
    wait_done(-1, cyc);
    finish_sweep("ideal", cyc);

    start_sweep(1);
    wait_done(-1, cyc);
    finish_sweep("cout0", cyc);

    start_sweep(2);
    wait_done(-1, cyc);
    finish_sweep("sum0", cyc);

    start_sweep(0);
    wait_done(31, cyc);
    finish_sweep("repulse", cyc);

    // Reset in the first HOLD cycle of vector 40 with errors already recorded.
    start_sweep(1);
    cyc = 1;
    while (cyc < 121) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    part = model(1, 40);
    chk("mid_vec", 32'({FA, FB}), 32'h28);
    chk("mid_err", 32'(err_cnt), 32'(part.errs));
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;

    start_sweep(0);
    wait_done(-1, cyc);
    finish_sweep("after_rst", cyc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
